// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle RV32M multiply/divide unit (single-cycle multiply,
//               radix-2 restoring divide) with busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero  = '0;
    localparam logic [WIDTH-1:0] c_min_neg   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_all_ones  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_funct3;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    // Request decode, evaluated on the live operands while IDLE
    logic             w_req_div;
    logic             w_req_signed;
    logic             w_req_dbz;
    logic             w_req_ovf;
    logic             w_req_special;
    logic [WIDTH-1:0] w_special_res;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_req_div     = funct3[2];
    assign w_req_signed  = ~funct3[0];
    assign w_req_dbz     = (b == '0);
    assign w_req_ovf     = w_req_signed && (a == c_min_neg) && (b == c_all_ones);
    assign w_req_special = w_req_div && (w_req_dbz || w_req_ovf);
    assign w_special_res = w_req_dbz ? (funct3[1] ? a : c_all_ones)
                                     : (funct3[1] ? '0 : c_min_neg);
    assign w_a_mag       = (w_req_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag       = (w_req_signed && b[WIDTH-1]) ? -b : b;

    // Sign-extending to 2*WIDTH is equivalent to the 33-bit extension, modulo 2^64
    logic               w_mul_sa;
    logic               w_mul_sb;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mul_res;

    assign w_mul_sa  = (r_funct3[1:0] == 2'b01) || (r_funct3[1:0] == 2'b10);
    assign w_mul_sb  = (r_funct3[1:0] == 2'b01);
    assign w_a_ext   = {{WIDTH{w_mul_sa & r_a[WIDTH-1]}}, r_a};
    assign w_b_ext   = {{WIDTH{w_mul_sb & r_b[WIDTH-1]}}, r_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = (r_funct3[1:0] == 2'b00) ? w_prod[WIDTH-1:0]
                                                : w_prod[2*WIDTH-1:WIDTH];

    // One restoring-division step; remainder stays below divisor so the
    // difference always fits in WIDTH bits when it is taken
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_div_res;
    logic [WIDTH-1:0] w_calc_res;

    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
    assign w_sub      = w_rem_sh[WIDTH-1:0] - r_dvs;
    assign w_rem_nxt  = w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_ge};
    assign w_div_res  = r_funct3[1] ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                                    : (r_neg_q ? -w_quo_nxt : w_quo_nxt);
    assign w_calc_res = r_funct3[2] ? w_div_res : w_mul_res;

    logic             w_accept;
    logic             w_write;
    logic [WIDTH-1:0] w_res_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_write     = 1'b0;
        w_res_nxt   = w_calc_res;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (!w_req_div) begin
                        w_state_nxt = S_MUL;
                    end else if (w_req_special) begin
                        w_state_nxt = S_DONE;
                        w_write     = 1'b1;
                        w_res_nxt   = w_special_res;
                    end else begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: begin
                w_state_nxt = S_DONE;
                w_write     = 1'b1;
            end
            S_DIV: begin
                if (r_cnt == c_cnt_zero) begin
                    w_state_nxt = S_DONE;
                    w_write     = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_write     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_funct3 <= '0;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_busy <= (w_state_nxt == S_MUL) || (w_state_nxt == S_DIV);
            r_done <= (w_state_nxt == S_DONE);
            if (w_write) begin
                r_result <= w_res_nxt;
            end
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_funct3 <= funct3;
                r_cnt    <= c_last_iter;
                r_quo    <= w_a_mag;
                r_rem    <= '0;
                r_dvs    <= w_b_mag;
                r_neg_q  <= w_req_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_r  <= w_req_signed && a[WIDTH-1];
            end else if ((r_state == S_DIV) && !flush) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt - c_cnt_one;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit: results, latency, flush, reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv);
        longint          xa;
        longint          xb;
        longint          p;
        longint unsigned pu;
        int              ia;
        int              ib;
        logic            ovf;
        logic [31:0]     r;
        xa  = longint'($signed(av));
        xb  = longint'($signed(bv));
        ia  = $signed(av);
        ib  = $signed(bv);
        ovf = (av == 32'h8000_0000) && (bv == 32'hFFFF_FFFF);
        r   = '0;
        case (f3)
            3'd0: begin p = xa * xb; r = p[31:0]; end
            3'd1: begin p = xa * xb; r = p[63:32]; end
            3'd2: begin p = xa * longint'({32'd0, bv}); r = p[63:32]; end
            3'd3: begin pu = {32'd0, av} * {32'd0, bv}; r = pu[63:32]; end
            3'd4: r = (bv == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
            3'd5: r = (bv == 0) ? 32'hFFFF_FFFF : av / bv;
            3'd6: r = (bv == 0) ? av : (ovf ? 32'd0 : 32'(ia % ib));
            default: r = (bv == 0) ? av : av % bv;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv);
        if (!f3[2]) return 2;
        if (bv == 0 || (!f3[0] && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Result checking happens here, independent of the stimulus tasks
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                check("result", result, sb.pop_front());
            end
        end
    end

    task automatic do_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp, input int exp_lat, input int exp_busy, input bit hold);
        int lat;
        int nbusy;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        a      = av;
        b      = bv;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        lat   = 0;
        nbusy = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = cyc;
                break;
            end
            if (hold) begin
                a      = $urandom;
                b      = $urandom;
                funct3 = 3'($urandom);
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(nbusy), 32'(exp_busy));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("done_pulse", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] av;
        logic [31:0] bv;
        int          l;

        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = '0;
        a      = '0;
        b      = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Multiplies
        do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1, 1'b0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 1, 1'b0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1, 1'b0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1, 1'b0);

        // Normal divides
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32, 1'b0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32, 1'b0);
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 32, 1'b0);
        do_op(3'd7, 32'd100, 32'd7, 32'd2,  33, 32, 1'b0);

        // Special cases
        do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
        do_op(3'd6, 32'd5, 32'd0, 32'd5,         1, 0, 1'b0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0, 1'b0);

        // start held with churning operands through busy and DONE
        do_op(3'd4, 32'd1000, 32'd7, 32'd142, 33, 32, 1'b1);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 2, 1, 1'b1);

        // Flush during iteration 10, then immediate restart
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd4;
        a      = 32'd1000;
        b      = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_state", {30'd0, busy, done}, 32'd0);
        do_op(3'd4, 32'd9, 32'd3, 32'd3, 33, 32, 1'b0);

        // Asynchronous reset mid-divide
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd5;
        a      = 32'd100;
        b      = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_done", {31'd0, done}, 32'd0);
        check("areset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {30'd0, busy, done}, 32'd0);
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 32, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom);
            av = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = 32'd0;
                1:       bv = $urandom_range(1, 20);
                default: bv = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                av = 32'h8000_0000;
                bv = 32'hFFFF_FFFF;
            end
            l = ref_lat(f3, av, bv);
            do_op(f3, av, bv, ref_op(f3, av, bv), l, (l == 33) ? 32 : ((l == 2) ? 1 : 0), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
